// File: rtl/arm_alu_pkg.sv
// Shared command encodings and status-register layout for the pipelined ARM ALU.
package arm_alu_pkg;

    localparam int unsigned CMD_W = 4;
    localparam int unsigned SR_W  = 4;

    localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] CMD_MUL = 4'b1010;

    localparam int unsigned SR_Z = 3;
    localparam int unsigned SR_C = 2;
    localparam int unsigned SR_N = 1;
    localparam int unsigned SR_V = 0;

endpackage

// File: rtl/arm_seq_multiplier.sv
// Radix-2 shift-add multiplier returning the low WIDTH bits of a*b.
// The first partial product is taken on the start edge, so the last of CYCLES iterations lands on done.
module arm_seq_multiplier #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned      CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYCLES - 1);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] partial;

    // product is the accumulator after this cycle's iteration; valid while done is high
    always_comb begin
        partial = mplier[0] ? mcand : '0;
        product = acc + partial;
        done    = running && (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (flush) begin
            running <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CNT_W'(1);
            acc     <= b[0] ? a : '0;
            mcand   <= a << 1;
            mplier  <= b >> 1;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arm_pipe_alu.sv
// Registered execute-stage ALU with valid/ready handshake, own {Z,C,N,V} status and a multi-cycle MUL.
import arm_alu_pkg::*;

module arm_pipe_alu #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  alu_cmd,
    input  logic [WIDTH-1:0]  val1,
    input  logic [WIDTH-1:0]  val2,
    input  logic              c_in,
    input  logic              s_bit,
    output logic              out_valid,
    output logic [WIDTH-1:0]  alu_out,
    output logic [SR_W-1:0]   sr,
    output logic              busy
);

    localparam int unsigned M = WIDTH - 1;

    logic             accept;
    logic             is_mul;
    logic             mul_s;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             c_flag;
    logic             v_flag;
    logic             cv_wr;
    logic [SR_W-1:0]  sr_alu;
    logic [SR_W-1:0]  sr_mul;

    assign is_mul = (alu_cmd == CMD_MUL);
    assign accept = in_valid && in_ready && !flush;

    arm_seq_multiplier #(
        .WIDTH  (WIDTH),
        .CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .flush   (flush),
        .a       (val1),
        .b       (val2),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath; sums are one bit wider so the top bit is carry / borrow
    always_comb begin
        sum    = {1'b0, val1} + {1'b0, val2} + (WIDTH+1)'(alu_cmd == CMD_ADC && c_in);
        diff   = {1'b0, val1} - {1'b0, val2} - (WIDTH+1)'(alu_cmd == CMD_SBC && !c_in);
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        cv_wr  = 1'b0;
        case (alu_cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD, CMD_ADC: begin
                res    = sum[WIDTH-1:0];
                c_flag = sum[WIDTH];
                v_flag = (val1[M] == val2[M]) && (sum[M] != val1[M]);
                cv_wr  = 1'b1;
            end
            CMD_SUB, CMD_SBC: begin
                res    = diff[WIDTH-1:0];
                c_flag = !diff[WIDTH];
                v_flag = (val1[M] != val2[M]) && (diff[M] != val1[M]);
                cv_wr  = 1'b1;
            end
            CMD_AND: res = val1 & val2;
            CMD_ORR: res = val1 | val2;
            CMD_EOR: res = val1 ^ val2;
            default: res = '0;
        endcase
    end

    // Candidate status values; C and V only move for add/subtract
    always_comb begin
        sr_alu       = sr;
        sr_alu[SR_Z] = (res == '0);
        sr_alu[SR_N] = res[M];
        if (cv_wr) begin
            sr_alu[SR_C] = c_flag;
            sr_alu[SR_V] = v_flag;
        end
        sr_mul       = sr;
        sr_mul[SR_Z] = (mul_product == '0);
        sr_mul[SR_N] = mul_product[M];
    end

    // flush outranks both a MUL completion and a new accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            alu_out   <= '0;
            sr        <= '0;
            mul_s     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                busy     <= 1'b0;
                in_ready <= 1'b1;
            end else if (busy) begin
                if (mul_done) begin
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b1;
                    alu_out   <= mul_product;
                    if (mul_s) begin
                        sr <= sr_mul;
                    end
                end
            end else if (accept) begin
                if (is_mul) begin
                    busy     <= 1'b1;
                    in_ready <= 1'b0;
                    mul_s    <= s_bit;
                end else begin
                    out_valid <= 1'b1;
                    alu_out   <= res;
                    if (s_bit) begin
                        sr <= sr_alu;
                    end
                end
            end
        end
    end

endmodule

// File: doc/arm_pipe_alu.md
Name: arm_pipe_alu

Overview:
- Parametrised, registered successor to the execute-stage ALU of the ARM core.
- Accepts one command per cycle through a valid/ready handshake and returns a registered result one cycle later.
- Adds a multi-cycle MUL (radix-2 shift-add) that back-pressures the EXE stage.
- Holds its own status register {Z,C,N,V}, updated only when the captured S bit is set.

Parameters:
- WIDTH, 32, datapath width in bits (≥ 4).
- MUL_CYCLES, WIDTH, iterations of the shift-add multiplier (must equal WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of an in-flight command (branch taken / hazard kill).
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command this cycle.
- alu_cmd  in  4  command code.
- val1  in  WIDTH  operand 1.
- val2  in  WIDTH  operand 2.
- c_in  in  1  carry input for ADC/SBC.
- s_bit  in  1  update status register on completion.
- out_valid  out  1  one-cycle pulse: alu_out/sr are new.
- alu_out  out  WIDTH  registered result, held until the next completion.
- sr  out  4  status register {Z,C,N,V}, bit 3 = Z … bit 0 = V.
- busy  out  1  multiplier iterating.

Behaviour:
- Reset (async, rst=1):
  - in_ready=1, out_valid=0, busy=0, alu_out=0, sr=0.
  - Multiplier counter and accumulator cleared.
  - Asserting reset mid-MUL aborts the multiply with no completion.
- Accept:
  - A command is accepted on an edge where in_valid & in_ready & ~flush.
  - All inputs, including s_bit and c_in, are captured on that edge.
- Command codes (unchanged from the current ALU):
  - MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000.
  - New: MUL=1010.
  - CMP, LDR, STR and TST share the SUB, ADD and AND codes.
- Single-cycle ops:
  - Command accepted at edge T → out_valid=1 in cycle T+1.
  - Throughput is one per cycle; in_ready stays 1.
- MUL:
  - On accept: busy=1 and in_ready=0 from the next cycle.
  - Iterates MUL_CYCLES edges, then completes: out_valid pulses in cycle T+MUL_CYCLES.
  - in_ready returns to 1 in that same cycle.
  - Result is the low WIDTH bits of val1*val2 (unsigned = signed for the low half).
- in_valid while busy: not accepted; upstream must hold the command stable.
- Arithmetic (M = WIDTH-1, all sums computed WIDTH+1 wide):
  - ADD/ADC:
    - {C,R} = val1 + val2 (+c_in for ADC).
    - V = (val1[M]==val2[M]) & (R[M]!=val1[M]).
  - SUB/SBC:
    - R = val1 - val2 (- ~c_in for SBC).
    - C = NOT borrow, ARM convention: SUB gives C=1 iff val1 ≥ val2 unsigned.
    - V = (val1[M]!=val2[M]) & (R[M]!=val1[M]).
  - MOV, MVN, AND, ORR, EOR, MUL: result only.
  - Unknown code: R=0, still completes in one cycle.
- Flag update (on completion only, and only if the captured s_bit=1):
  - N=R[M], Z=(R==0) for every op.
  - C and V are written only by ADD/ADC/SUB/SBC; all other ops hold them.
  - s_bit=0: sr unchanged. The result still drives out_valid and alu_out.
- flush:
  - Kills a pending single-cycle completion or an in-flight MUL.
  - No out_valid, sr and alu_out unchanged, busy=0, in_ready=1 next cycle.
  - flush together with in_valid: flush wins, nothing is accepted.
- Wrap-around:
  - ADD of 0xFFFFFFFF+1 → R=0, C=1.
  - SUB of 0-1 → R=0xFFFFFFFF, C=0.

Decomposition:
- Package arm_alu_pkg holds:
  - the 4-bit command localparams (MOV…MUL);
  - SR bit indices SR_Z=3, SR_C=2, SR_N=1, SR_V=0.
- Sub-module arm_seq_multiplier (WIDTH), shift-add with a counter:
  - inputs start, flush, a, b;
  - outputs done (one-cycle pulse), product[WIDTH-1:0].
- The top level holds the handshake, single-cycle datapath, output registers and sr.

Test Plan:
- Reset then ADD, s_bit=1, val1=0x7FFFFFFF, val2=1 → next cycle out_valid=1, alu_out=0x80000000, sr=4'b0011 (N=1,V=1).
- Back-to-back: SUB 5-5 (s=1) then AND 0xF0F0&0x0FF0 (s=1) on consecutive cycles → two consecutive out_valid pulses, alu_out 0 then 0x00F0. sr after SUB = 4'b1100 (Z,C); after AND = 4'b0100 (C held, Z cleared).
- MUL 7×6 (WIDTH=32), s=1 → in_ready=0 for 31 cycles, out_valid exactly at T+32, alu_out=42, sr N=0, Z=0, C/V unchanged. A command held on in_valid during MUL is accepted only when in_ready returns.
- SBC with c_in=0, val1=0, val2=0 → alu_out=0xFFFFFFFF, C=0, N=1. The same with s_bit=0 leaves sr unchanged.
- flush at cycle T+10 of a MUL, and flush together with in_valid → no out_valid, alu_out/sr hold previous values, busy=0, in_ready=1 the next cycle.
- Assert rst mid-MUL (cycle T+5) → immediately alu_out=0, sr=0, out_valid=0, busy=0. No completion pulse after release.
